// File: rtl/tt_um_wokwi_434925031692840961.sv
// Up/down 8-bit counter with a 7-bit free-running prescaler, parallel load, clear,
// and a selectable binary or seven-segment hex display (bit 7 = wrap flag).
module tt_um_wokwi_434925031692840961 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DATA_W = 8;
  localparam int PS_W   = 7;

  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic              wf_q, wf_d;

  logic       cnt_en, dir_up, load, mode, clr;
  logic [2:0] sel;
  logic [PS_W-1:0] tick_mask;
  logic       tick;

  assign cnt_en = ui_in[0];
  assign dir_up = ui_in[1];
  assign load   = ui_in[2];
  assign mode   = ui_in[3];
  assign clr    = ui_in[4];
  assign sel    = ui_in[7:5];

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // sel=0 yields an empty mask, so the tick is asserted every clock.
  assign tick_mask = PS_W'((8'd1 << sel) - 8'd1);
  assign tick      = ((ps_q & tick_mask) == tick_mask);

  always_comb begin
    cnt_d = cnt_q;
    ps_d  = ps_q;
    wf_d  = wf_q;
    if (ena) begin
      ps_d = ps_q + PS_W'(1);
      wf_d = 1'b0;
      if (clr) begin
        cnt_d = '0;
      end else if (load) begin
        cnt_d = uio_in;
      end else if (tick && cnt_en) begin
        if (dir_up) begin
          cnt_d = cnt_q + DATA_W'(1);
          wf_d  = (cnt_q == 8'hFF);
        end else begin
          cnt_d = cnt_q - DATA_W'(1);
          wf_d  = (cnt_q == 8'h00);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ps_q  <= '0;
      wf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
      wf_q  <= wf_d;
    end
  end

  assign uo_out  = mode ? {wf_q, seg7(cnt_q[3:0])} : cnt_q;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_wokwi_434925031692840961.sv
// Bench for the prescaled up/down counter: directed scenarios plus random traffic,
// all checked against an arithmetic reference model.
module tb_tt_um_wokwi_434925031692840961;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  int m_cnt = 0;
  int m_ps  = 0;
  int m_wf  = 0;

  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  tt_um_wokwi_434925031692840961 dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] exp_uo();
    if (ui_in[3]) return {m_wf[0], glyph[m_cnt % 16]};
    return 8'(m_cnt);
  endfunction

  // Reference behaviour of one rising edge, evaluated from the inputs held before it.
  task automatic model_edge();
    int period;
    bit t;
    if (!rst_n || !ena) return;
    period = 1 << ui_in[7:5];
    t = ((m_ps % period) == period - 1);
    m_ps = (m_ps + 1) % 128;
    m_wf = 0;
    if (ui_in[4]) m_cnt = 0;
    else if (ui_in[2]) m_cnt = uio_in;
    else if (t && ui_in[0]) begin
      if (ui_in[1]) begin
        m_wf = (m_cnt == 255);
        m_cnt = (m_cnt + 1) % 256;
      end else begin
        m_wf = (m_cnt == 0);
        m_cnt = (m_cnt + 255) % 256;
      end
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_edge();
      #2;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m_cnt = 0; m_ps = 0; m_wf = 0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
    rst_n = 1'b0;
    #2;
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL reset_mode0 got=%h want=00", uo_out); end
    ui_in = 8'h08;
    #1;
    total++;
    if (uo_out !== 8'h3F) begin bad++; $display("FAIL reset_mode1 got=%h want=3F", uo_out); end
    total++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      bad++; $display("FAIL reset_uio got=%h/%h want=00/00", uio_out, uio_oe);
    end
    ui_in = 8'h00;
    m_cnt = 0; m_ps = 0; m_wf = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    ena = 1'b1; ui_in = 8'h03;
    step(5);
    total++;
    if (uo_out !== 8'h05) begin bad++; $display("FAIL count_up5 got=%h want=05", uo_out); end
  endtask

  task automatic test_wrap_up();
    uio_in = 8'hFE; ui_in = 8'h04;
    step(1);
    total++;
    if (uo_out !== 8'hFE) begin bad++; $display("FAIL load_fe got=%h want=FE", uo_out); end
    ui_in = 8'h0B;
    step(2);
    total++;
    if (uo_out !== 8'hBF) begin bad++; $display("FAIL wrap_up_wf got=%h want=BF", uo_out); end
    step(1);
    total++;
    if (uo_out !== 8'h06) begin bad++; $display("FAIL after_wrap got=%h want=06", uo_out); end
  endtask

  task automatic test_wrap_down();
    ui_in = 8'h10;
    step(1);
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL clear got=%h want=00", uo_out); end
    ui_in = 8'h01;
    step(1);
    total++;
    if (uo_out !== 8'hFF) begin bad++; $display("FAIL down_wrap got=%h want=FF", uo_out); end
    ui_in = 8'h09;
    #1;
    total++;
    if (uo_out !== 8'hF1) begin bad++; $display("FAIL down_wf got=%h want=F1", uo_out); end
    step(1);
    total++;
    if (uo_out !== 8'h79) begin bad++; $display("FAIL wf_one_cycle got=%h want=79", uo_out); end
  endtask

  task automatic test_prescale();
    @(negedge clk);
    apply_reset();
    ena = 1'b1; ui_in = 8'h63;
    step(7);
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL presc7 got=%h want=00", uo_out); end
    step(1);
    total++;
    if (uo_out !== 8'h01) begin bad++; $display("FAIL presc8 got=%h want=01", uo_out); end
    step(8);
    total++;
    if (uo_out !== 8'h02) begin bad++; $display("FAIL presc16 got=%h want=02", uo_out); end
  endtask

  task automatic test_clear_load();
    uio_in = 8'h55; ui_in = 8'h14;
    step(1);
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL clr_over_load got=%h want=00", uo_out); end
    ui_in = 8'h04;
    step(1);
    total++;
    if (uo_out !== 8'h55) begin bad++; $display("FAIL load55 got=%h want=55", uo_out); end
    ui_in = 8'h03; ena = 1'b0;
    step(10);
    total++;
    if (uo_out !== 8'h55) begin bad++; $display("FAIL ena_hold got=%h want=55", uo_out); end
    ena = 1'b1;
    step(1);
    total++;
    if (uo_out !== 8'h56) begin bad++; $display("FAIL ena_resume got=%h want=56", uo_out); end
  endtask

  task automatic test_async_reset();
    uio_in = 8'h37; ui_in = 8'h04;
    step(1);
    ui_in = 8'h03;
    #1;
    total++;
    if (uo_out !== 8'h37) begin bad++; $display("FAIL pre_rst got=%h want=37", uo_out); end
    rst_n = 1'b0;
    m_cnt = 0; m_ps = 0; m_wf = 0;
    #1;
    total++;
    if (uo_out !== 8'h00) begin bad++; $display("FAIL async_rst got=%h want=00", uo_out); end
    total++;
    if (uio_oe !== 8'h00) begin bad++; $display("FAIL rst_uio_oe got=%h want=00", uio_oe); end
    rst_n = 1'b1;
    step(1);
    total++;
    if (uo_out !== 8'h01) begin bad++; $display("FAIL restart got=%h want=01", uo_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] u;
      u = 8'($urandom);
      u[4] = ($urandom_range(0, 15) == 0);
      u[2] = ($urandom_range(0, 15) == 0);
      u[0] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 1) == 0) u[7:5] = 3'($urandom_range(0, 1));
      ui_in  = u;
      uio_in = 8'($urandom);
      ena    = ($urandom_range(0, 9) != 0);
      step(1);
      total++;
      if (uo_out !== exp_uo()) begin
        bad++; $display("FAIL random[%0d] got=%h want=%h ui=%h", i, uo_out, exp_uo(), ui_in);
      end
      total++;
      if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
        bad++; $display("FAIL random_uio[%0d] got=%h/%h want=00/00", i, uio_out, uio_oe);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap_up();
    test_wrap_down();
    test_prescale();
    test_clear_load();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
